// File: rtl/spi_cmd_ram_v2.sv
// spi_cmd_ram_v2: single-port command RAM sitting behind an SPI slave.
// Command words carry a 2-bit opcode and a payload:
//   00 set write address, 01 write data, 10 set read address, 11 read.
// Read data goes back to the SPI transmit side over a valid/ready handshake.
// Optional feature: define SPI_CMD_RAM_AUTO_INC_EN to post-increment the write
// address after every data write and the read address after every read.
module spi_cmd_ram_v2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned PAYLOAD_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAYLOAD_W+1:0]  din,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  overrun,
  output logic                  addr_err
);

  localparam int unsigned MemAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
  localparam logic [ADDR_SIZE:0] DepthW = (ADDR_SIZE + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    OpWrAddr = 2'b00,
    OpWrData = 2'b01,
    OpRdAddr = 2'b10,
    OpRead   = 2'b11
  } op_e;

  state_e                state_q;
  logic                  rx_ready_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  tx_valid_q;
  logic                  overrun_q;
  logic                  addr_err_q;
  logic [ADDR_SIZE-1:0]  wr_addr_q;
  logic [ADDR_SIZE-1:0]  rd_addr_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  op_e                   opcode;
  logic [ADDR_SIZE-1:0]  pl_addr;
  logic [DATA_WIDTH-1:0] pl_data;
  logic                  accept;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  unused_din;

  assign opcode  = op_e'(din[PAYLOAD_W+1:PAYLOAD_W]);
  assign pl_addr = din[ADDR_SIZE-1:0];
  assign pl_data = din[DATA_WIDTH-1:0];
  // Upper payload bits beyond both fields are don't-care.
  assign unused_din = ^din;

  // rx_ready_q is high exactly in StIdle, so it doubles as the acceptance gate.
  assign accept      = rx_valid && rx_ready_q;
  assign wr_in_range = {1'b0, wr_addr_q} < DepthW;
  assign rd_in_range = {1'b0, rd_addr_q} < DepthW;

`ifdef SPI_CMD_RAM_AUTO_INC_EN
  localparam logic [ADDR_SIZE:0] LastW = (ADDR_SIZE + 1)'(MEM_DEPTH - 1);

  logic [ADDR_SIZE-1:0] wr_addr_inc;
  logic [ADDR_SIZE-1:0] rd_addr_inc;

  // Wrapping increments; anything at or past the last word wraps to 0.
  always_comb begin
    wr_addr_inc = wr_addr_q + 1'b1;
    rd_addr_inc = rd_addr_q + 1'b1;
    if ({1'b0, wr_addr_q} >= LastW) wr_addr_inc = '0;
    if ({1'b0, rd_addr_q} >= LastW) rd_addr_inc = '0;
  end
`endif

  // Memory write port: only in-range data writes accepted in StIdle.
  always_ff @(posedge clk) begin
    if (!rst && accept && (opcode == OpWrData) && wr_in_range) begin
      mem[wr_addr_q[MemAw-1:0]] <= pl_data;
    end
  end

  // Command decode, read sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rx_ready_q <= 1'b1;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      addr_err_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      // Any command offered outside StIdle is dropped with a one-cycle flag.
      overrun_q <= rx_valid && !rx_ready_q;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            unique case (opcode)
              OpWrAddr: wr_addr_q <= pl_addr;
              OpWrData: begin
                if (!wr_in_range) addr_err_q <= 1'b1;
`ifdef SPI_CMD_RAM_AUTO_INC_EN
                wr_addr_q <= wr_addr_inc;
`endif
              end
              OpRdAddr: rd_addr_q <= pl_addr;
              OpRead: begin
                state_q    <= StRd;
                rx_ready_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        StRd: begin
          tx_valid_q <= 1'b1;
          state_q    <= StHold;
          if (rd_in_range) begin
            dout_q <= mem[rd_addr_q[MemAw-1:0]];
          end else begin
            dout_q     <= '0;
            addr_err_q <= 1'b1;
          end
`ifdef SPI_CMD_RAM_AUTO_INC_EN
          rd_addr_q <= rd_addr_inc;
`endif
        end
        StHold: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q    <= StIdle;
          rx_ready_q <= 1'b1;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign overrun  = overrun_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_cmd_ram_v2.sv
// Bench for spi_cmd_ram_v2: directed command sequences; expected read data is
// queued when a read is issued and checked by a monitor on each tx handshake.
module tb_spi_cmd_ram_v2;

`ifdef SPI_CMD_RAM_AUTO_INC_EN
  localparam int unsigned Depth = 256;
`else
  localparam int unsigned Depth = 200;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] dout;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       overrun;
  logic       addr_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  spi_cmd_ram_v2 #(
    .DATA_WIDTH(8),
    .ADDR_SIZE (8),
    .MEM_DEPTH (Depth),
    .PAYLOAD_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .dout    (dout),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .overrun (overrun),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed tx handshake must match the oldest queued value.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        chk("rd_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  // Present one command for one cycle; entered and left 1ns after a rising edge.
  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    rx_valid = 1'b1;
    din      = {op, pl};
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue a read with tx_ready high and let it complete.
  task automatic read_now(input logic [7:0] exp);
    exp_q.push_back(exp);
    cmd(2'b11, 8'h00);
    cycles(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_addr_err", 32'(addr_err), 0);

    // Basic write then read, with latency checks.
    tx_ready = 1'b1;
    cmd(2'b00, 8'h10);
    cmd(2'b01, 8'h5A);
    cmd(2'b10, 8'h10);
    exp_q.push_back(8'h5A);
    cmd(2'b11, 8'h00);
    chk("lat_k_tx_valid", 32'(tx_valid), 0);
    chk("lat_k_rx_ready", 32'(rx_ready), 0);
    cycles(1);
    chk("lat_k1_tx_valid", 32'(tx_valid), 1);
    chk("lat_k1_dout", 32'(dout), 32'h5A);
    chk("lat_k1_rx_ready", 32'(rx_ready), 0);
    cycles(1);
    chk("lat_k2_tx_valid", 32'(tx_valid), 0);
    chk("lat_k2_rx_ready", 32'(rx_ready), 1);

    // Back-pressure with an overrun attempt during HOLD.
    tx_ready = 1'b0;
    cmd(2'b00, 8'h20);
    cmd(2'b01, 8'h3C);
    cmd(2'b00, 8'h20);
    cmd(2'b10, 8'h20);
    exp_q.push_back(8'h3C);
    cmd(2'b11, 8'h00);
    cycles(1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_tx_valid", 32'(tx_valid), 1);
      chk("hold_dout", 32'(dout), 32'h3C);
      chk("hold_rx_ready", 32'(rx_ready), 0);
      if (i == 0) begin
        rx_valid = 1'b1;
        din      = {2'b01, 8'hFF};
      end
      cycles(1);
      if (i == 0) begin
        rx_valid = 1'b0;
        chk("overrun_pulse", 32'(overrun), 1);
      end else if (i == 1) begin
        chk("overrun_clear", 32'(overrun), 0);
      end
    end
    tx_ready = 1'b1;
    cycles(1);
    chk("release_tx_valid", 32'(tx_valid), 0);
    chk("release_rx_ready", 32'(rx_ready), 1);
    // Dropped write must not have touched 0x20.
    cmd(2'b10, 8'h20);
    read_now(8'h3C);

`ifdef SPI_CMD_RAM_AUTO_INC_EN
    // Auto-increment across the top of the address space.
    cmd(2'b00, 8'hFE);
    cmd(2'b01, 8'hA1);
    cmd(2'b01, 8'hA2);
    cmd(2'b01, 8'hA3);
    cmd(2'b10, 8'hFE);
    read_now(8'hA1);
    read_now(8'hA2);
    read_now(8'hA3);
`else
    // Without auto-increment, repeated writes and reads hit one address.
    cmd(2'b00, 8'h30);
    cmd(2'b01, 8'h11);
    cmd(2'b01, 8'h22);
    cmd(2'b10, 8'h30);
    read_now(8'h22);
    read_now(8'h22);

    // Out-of-range write and read at the depth boundary.
    cmd(2'b00, 8'hC7);
    cmd(2'b01, 8'h44);
    chk("inrange_no_err", 32'(addr_err), 0);
    cmd(2'b00, 8'hC8);
    cmd(2'b01, 8'h33);
    chk("oor_wr_err", 32'(addr_err), 1);
    cmd(2'b10, 8'hC7);
    read_now(8'h44);
    cmd(2'b10, 8'hC8);
    read_now(8'h00);
    chk("oor_err_sticky", 32'(addr_err), 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("oor_err_cleared", 32'(addr_err), 0);
`endif

    // Reset during RD abandons the read and clears rd_addr.
    tx_ready = 1'b1;
    cmd(2'b00, 8'h00);
    cmd(2'b01, 8'h77);
    cmd(2'b10, 8'h10);
    cmd(2'b11, 8'h00);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("midrd_tx_valid", 32'(tx_valid), 0);
    chk("midrd_dout", 32'(dout), 0);
    chk("midrd_rx_ready", 32'(rx_ready), 1);
    read_now(8'h77);

    cycles(2);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ram_v2.md
Name: spi_cmd_ram_v2

Overview:
- Parametrised single-port command RAM behind the SPI slave.
- Decodes 2-bit-opcode command words from the SPI receive path: set write address, write data, set read address, read.
- Returns read data to the SPI transmit path with a valid/ready handshake.
- Over the prior generation, adds: independent data and address widths, a depth bound, back-pressure on both sides, error flags, and optional address auto-increment.

Parameters:
- DATA_WIDTH, 8, width of each memory word and of dout.
- ADDR_SIZE, 8, width of the write and read address registers.
- MEM_DEPTH, 256, number of words; must be at most 2**ADDR_SIZE.
- PAYLOAD_W, 8, command payload width; must be at least max(DATA_WIDTH, ADDR_SIZE).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  PAYLOAD_W+2  command word: din[PAYLOAD_W+1:PAYLOAD_W] = opcode, din[PAYLOAD_W-1:0] = payload.
- rx_valid  input  1  din valid.
- rx_ready  output  1  block can accept a command.
- dout  output  DATA_WIDTH  read data.
- tx_valid  output  1  dout valid.
- tx_ready  input  1  downstream consumes dout.
- overrun  output  1  one-cycle pulse: command presented while rx_ready = 0 and dropped.
- addr_err  output  1  sticky: an access used an address >= MEM_DEPTH; cleared only by rst.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values: rst high at a clk edge sets:
  - state = IDLE, rx_ready = 1.
  - dout = 0, tx_valid = 0, overrun = 0, addr_err = 0.
  - wr_addr = 0, rd_addr = 0.
  - Memory contents are not cleared.
  - A reset mid-read abandons the read; tx_valid is 0 the cycle after.
- Acceptance: a command is accepted at an edge where rx_valid = 1 and rx_ready = 1. rx_ready = 1 only in IDLE.
- Opcode 00: wr_addr <= payload[ADDR_SIZE-1:0].
- Opcode 01: mem[wr_addr] <= payload[DATA_WIDTH-1:0].
  - If wr_addr >= MEM_DEPTH: the write is suppressed and addr_err is set.
- Opcode 10: rd_addr <= payload[ADDR_SIZE-1:0].
- Opcode 11: the FSM moves IDLE -> RD.
- Unused upper payload bits are ignored.
- FSM states: IDLE, RD, HOLD.
  - IDLE: decode commands as above.
  - RD (one cycle): dout <= mem[rd_addr], tx_valid <= 1, next state HOLD.
    - If rd_addr >= MEM_DEPTH: dout <= 0 and addr_err is set; tx_valid is still asserted.
  - HOLD: dout and tx_valid are held stable until an edge with tx_ready = 1. At that edge tx_valid <= 0 and the next state is IDLE.
- Latency:
  - Read command accepted at edge k gives tx_valid = 1 after edge k+1.
  - If tx_ready is already 1, tx_valid drops after edge k+2 and rx_ready = 1 after edge k+2.
  - Maximum read throughput is one read per 3 cycles.
- Back-pressure:
  - rx_valid = 1 in RD or HOLD drops the command and pulses overrun for exactly one cycle, the cycle after that edge.
  - One pulse is generated per edge of such a command.
  - No state or memory change results from a dropped command.
- Memory is inferred synchronous single-port, one access per cycle. No write and read can coincide, because writes occur only in IDLE.
- No X on outputs after reset.

Optional Feature:
- Macro: SPI_CMD_RAM_AUTO_INC_EN.
- Defined:
  - After every accepted opcode 01, wr_addr <= wr_addr + 1. This happens even if the write was suppressed.
  - After every completed RD state, rd_addr <= rd_addr + 1.
  - Increment wraps MEM_DEPTH-1 -> 0. Any address >= MEM_DEPTH also wraps to 0 on increment.
  - An explicit 00 or 10 loads the address without incrementing.
- Undefined: addresses change only on opcodes 00 and 10; identical to the description above.

Test Plan:
- Reset, write 0x5A: rst 1 cycle; send 00_0x10, 01_0x5A, 10_0x10, 11_x, with tx_ready = 1 -> dout = 0x5A with tx_valid high for exactly one cycle, asserted 1 edge after the 11 command; rx_ready returns to 1 two edges after it.
- Back-pressure: tx_ready = 0 during a read; hold 4 cycles then raise tx_ready -> dout and tx_valid stable all 4 cycles; tx_valid falls on the edge with tx_ready = 1.
- Overrun: send 01_0xFF while in HOLD -> overrun = 1 for one cycle; memory unchanged (a later read of that address returns its old value); rx_ready = 0 throughout HOLD.
- Out of range (MEM_DEPTH = 200, ADDR_SIZE = 8): 00_0xC8, 01_0x33, then 10_0xC8, 11 -> no write; dout = 0; addr_err = 1 until rst.
- AUTO_INC (macro defined): 00_0xFE, then 01_0xA1, 01_0xA2, 01_0xA3; 10_0xFE, then three reads -> reads return A1, A2, A3 (addresses 0xFE, 0xFF, 0x00).
- Reset mid-read: rst asserted in RD -> tx_valid = 0, dout = 0, rx_ready = 1 the following cycle; rd_addr = 0.
